// File: rtl/ball_engine_pkg.sv
// Shared Pong field, ball and paddle constants, FSM state type and paddle helpers.
// Used by the ball engine, the paddle controllers and the renderer.
package ball_engine_pkg;

  localparam int unsigned SCREEN_W    = 800;
  localparam int unsigned SCREEN_H    = 480;
  localparam int unsigned BALL_SIZE   = 6;
  localparam int unsigned PADDLE_STEP = 16;
  localparam int unsigned PADDLE_H    = 64;
  localparam int unsigned POS_MAX     = 25;
  localparam int unsigned LEFT_PAD_X  = 18;
  localparam int unsigned RIGHT_PAD_X = 782;

  localparam logic [9:0] BALL_X_MAX    = 10'(SCREEN_W - BALL_SIZE);
  localparam logic [8:0] BALL_Y_MAX    = 9'(SCREEN_H - BALL_SIZE);
  localparam logic [9:0] CENTRE_X      = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [8:0] CENTRE_Y      = 9'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [9:0] AI_FACE_X     = 10'(RIGHT_PAD_X - BALL_SIZE);
  localparam logic [9:0] PLAYER_FACE_X = 10'(LEFT_PAD_X);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SERVE_WAIT = 2'd1,
    ST_PLAY       = 2'd2,
    ST_GAME_OVER  = 2'd3
  } state_e;

  // Paddle top edge in px; out-of-range positions clamp to POS_MAX (max 400, fits 10 bits).
  function automatic logic [9:0] paddle_top(input logic [7:0] pos);
    logic [9:0] p;
    p = (pos > 8'(POS_MAX)) ? 10'(POS_MAX) : {2'b00, pos};
    return 10'(p * PADDLE_STEP);
  endfunction

  function automatic logic paddle_hit(input logic [8:0] y, input logic [7:0] pos);
    logic [9:0] top;
    logic [9:0] yy;
    top = paddle_top(pos);
    yy  = {1'b0, y};
    return ((yy + 10'(BALL_SIZE)) > top) && (yy < (top + 10'(PADDLE_H)));
  endfunction

endpackage

// File: rtl/ball_engine_tick.sv
// Free-running TICK_DIV divider; tick_o is high for the single cycle the count is TICK_DIV-1.
module pong_tick #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ball_engine.sv
// Pong ball engine: serve/play/game-over FSM, ball motion, wall and paddle bounces, scoring.
// Original uppercase port names are kept so the renderer and paddle controllers hook up unchanged.
module ball_engine
  import ball_engine_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 100000,
  parameter int unsigned SERVE_DELAY = 50,
  parameter int unsigned WIN_SCORE   = 9
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       SERVE,
  input  logic [7:0] PLAYER_POS,
  input  logic [7:0] AI_POS,
  output logic [9:0] BALL_X,
  output logic [8:0] BALL_Y,
  output logic [3:0] SCORE_PLAYER,
  output logic [3:0] SCORE_AI,
  output logic       GAME_OVER
);

  localparam int unsigned SC_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

  state_e         state_q, state_d;
  logic [SC_W-1:0] serve_cnt_q, serve_cnt_d;
  logic [9:0]     x_q, x_d;
  logic [8:0]     y_q, y_d;
  logic           right_q, right_d;
  logic           down_q, down_d;
  logic [3:0]     score_p_q, score_p_d;
  logic [3:0]     score_a_q, score_a_d;
  logic           tick;
  logic           ai_hit, pl_hit;

  pong_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i  (CLOCK),
    .rst_i  (RESET),
    .tick_o (tick)
  );

  assign ai_hit = paddle_hit(y_q, AI_POS);
  assign pl_hit = paddle_hit(y_q, PLAYER_POS);

  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    right_d     = right_q;
    down_d      = down_q;
    score_p_d   = score_p_q;
    score_a_d   = score_a_q;

    unique case (state_q)
      ST_IDLE: begin
        if (SERVE) begin
          state_d     = ST_SERVE_WAIT;
          serve_cnt_d = '0;
        end
      end
      ST_SERVE_WAIT: begin
        if (tick) begin
          if (serve_cnt_q == SC_W'(SERVE_DELAY - 1)) begin
            state_d     = ST_PLAY;
            serve_cnt_d = '0;
          end else begin
            serve_cnt_d = serve_cnt_q + 1'b1;
          end
        end
      end
      ST_PLAY: begin
        if (tick) begin
          x_d = right_q ? x_q + 10'd1 : x_q - 10'd1;
          y_d = down_q  ? y_q + 9'd1  : y_q - 9'd1;
          // Wall and paddle flips are independent so a corner hit applies both.
          if (!down_q && y_q == '0) begin
            down_d = 1'b1;
            y_d    = y_q;
          end else if (down_q && y_q == BALL_Y_MAX) begin
            down_d = 1'b0;
            y_d    = y_q;
          end
          if (right_q && x_q == AI_FACE_X && ai_hit) begin
            right_d = 1'b0;
            x_d     = x_q;
          end else if (!right_q && x_q == PLAYER_FACE_X && pl_hit) begin
            right_d = 1'b1;
            x_d     = x_q;
          end
          if (right_q && x_q == BALL_X_MAX) begin
            score_p_d   = score_p_q + 4'd1;
            x_d         = CENTRE_X;
            y_d         = CENTRE_Y;
            right_d     = 1'b1;
            serve_cnt_d = '0;
            state_d     = (score_p_d == 4'(WIN_SCORE)) ? ST_GAME_OVER : ST_SERVE_WAIT;
          end else if (!right_q && x_q == '0) begin
            score_a_d   = score_a_q + 4'd1;
            x_d         = CENTRE_X;
            y_d         = CENTRE_Y;
            right_d     = 1'b0;
            serve_cnt_d = '0;
            state_d     = (score_a_d == 4'(WIN_SCORE)) ? ST_GAME_OVER : ST_SERVE_WAIT;
          end
        end
      end
      ST_GAME_OVER: begin
        if (SERVE) begin
          score_p_d   = '0;
          score_a_d   = '0;
          right_d     = 1'b1;
          serve_cnt_d = '0;
          state_d     = ST_SERVE_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      serve_cnt_q <= '0;
      x_q         <= CENTRE_X;
      y_q         <= CENTRE_Y;
      right_q     <= 1'b1;
      down_q      <= 1'b1;
      score_p_q   <= '0;
      score_a_q   <= '0;
    end else begin
      state_q     <= state_d;
      serve_cnt_q <= serve_cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      right_q     <= right_d;
      down_q      <= down_d;
      score_p_q   <= score_p_d;
      score_a_q   <= score_a_d;
    end
  end

  assign BALL_X       = x_q;
  assign BALL_Y       = y_q;
  assign SCORE_PLAYER = score_p_q;
  assign SCORE_AI     = score_a_q;
  assign GAME_OVER    = (state_q == ST_GAME_OVER);

endmodule
